// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the two-digit
// seven-segment scan driver.
package bcd_display_pkg;

    typedef enum logic [1:0] {
        S_D0,
        S_GAP0,
        S_D1,
        S_GAP1
    } state_t;

    typedef struct packed {
        logic [3:0] bcd1;
        logic [3:0] bcd0;
        logic       blank_lz;
    } digits_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] AN_OFF = 2'b11;
    localparam logic [1:0] AN_D0  = 2'b10;
    localparam logic [1:0] AN_D1  = 2'b01;

    function automatic int unsigned max2(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_display_mux_if.sv
// Load bus and display pins of the scan driver.
// The master supplies digits, the slave drives the display.
interface bcd_display_mux_if;

    logic       load;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    modport master (
        output load,
        output bcd0,
        output bcd1,
        output blank_lz,
        input  seg,
        input  an,
        input  err
    );

    modport slave (
        input  load,
        input  bcd0,
        input  bcd1,
        input  blank_lz,
        output seg,
        output an,
        output err
    );

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low gfedcba segments;
// values above 9 render as a dash.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        unique case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit common-anode scan driver with blanking gaps,
// shadow/active digit buffering and leading-zero blanking.
module bcd_display_mux
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
)(
    input  logic                clk,
    input  logic                rst_n,
    bcd_display_mux_if.slave    bus
);

    localparam int CW = $clog2(max2(REFRESH_DIV, BLANK_CYCLES));
    localparam logic [CW-1:0] D_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] G_LAST = CW'(BLANK_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          last;
    digits_t       shadow;
    digits_t       active;
    logic [3:0]    dig;
    logic [6:0]    dseg;
    logic          tens_blank;

    always_comb begin
        last     = 1'b0;
        state_nx = state;
        unique case (state)
            S_D0, S_D1: last = (cnt == D_LAST);
            default:    last = (cnt == G_LAST);
        endcase
        if (last) begin
            unique case (state)
                S_D0:    state_nx = S_GAP0;
                S_GAP0:  state_nx = S_D1;
                S_D1:    state_nx = S_GAP1;
                default: state_nx = S_D0;
            endcase
        end
    end

    // Active digits only change entering S_D0, so a scan is never torn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_GAP1;
            cnt    <= '0;
            shadow <= '0;
            active <= '0;
        end else begin
            state <= state_nx;
            cnt   <= last ? '0 : cnt + CW'(1);
            if (state == S_GAP1 && last) begin
                active <= shadow;
            end
            if (bus.load) begin
                shadow <= {bus.bcd1, bus.bcd0, bus.blank_lz};
            end
        end
    end

    assign dig = (state == S_D1) ? active.bcd1 : active.bcd0;

    seg7_decode u_dec (
        .bcd (dig),
        .seg (dseg)
    );

    assign tens_blank = active.blank_lz && (active.bcd1 == 4'd0);

    always_comb begin
        bus.an  = AN_OFF;
        bus.seg = SEG_BLANK;
        unique case (1'b1)
            (state == S_D0): begin
                bus.an  = AN_D0;
                bus.seg = dseg;
            end
            (state == S_D1) && !tens_blank: begin
                bus.an  = AN_D1;
                bus.seg = dseg;
            end
            default: ;
        endcase
    end

    assign bus.err = (active.bcd0 > 4'd9) || (active.bcd1 > 4'd9);

endmodule

// File: tb/tb_bcd_display_mux.sv
// Scoreboard bench: a cycle-indexed scan model predicts the
// display each cycle; a monitor pops and compares.
module tb_bcd_display_mux;

    localparam int R = 4;
    localparam int B = 2;
    localparam int P = 2 * (R + B);

    localparam logic [6:0] FONT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef struct packed {
        logic [1:0] an;
        logic [6:0] seg;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_display_mux_if bus ();

    bcd_display_mux #(
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    obs_t expq[$];
    int   checks = 0;
    int   failures = 0;

    // model: cycles since reset release, shadow and active pairs
    int         k;
    logic [3:0] s0, s1, a0, a1;
    logic       sblz, ablz;

    function automatic int phase(input int kk);
        return (kk + P - B) % P;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        if (d > 4'd9) return 7'h3F;
        return FONT[d];
    endfunction

    function automatic obs_t predict();
        obs_t o;
        int   q;
        q     = phase(k);
        o.an  = 2'b11;
        o.seg = 7'h7F;
        o.err = (a0 > 4'd9) || (a1 > 4'd9);
        if (q < R) begin
            o.an  = 2'b10;
            o.seg = glyph(a0);
        end else if (q >= R + B && q < 2 * R + B) begin
            if (!(ablz && a1 == 4'd0)) begin
                o.an  = 2'b01;
                o.seg = glyph(a1);
            end
        end
        return o;
    endfunction

    task automatic step(
        input bit         rst,
        input bit         ld,
        input logic [3:0] d0,
        input logic [3:0] d1,
        input bit         blz
    );
        @(negedge clk);
        expq.push_back(predict());
        rst_n        = rst;
        bus.load     = ld;
        bus.bcd0     = d0;
        bus.bcd1     = d1;
        bus.blank_lz = blz;
        if (!rst) begin
            k = 0;
            s0 = '0; s1 = '0; sblz = 1'b0;
            a0 = '0; a1 = '0; ablz = 1'b0;
        end else begin
            if (phase(k + 1) == 0) begin
                a0 = s0; a1 = s1; ablz = sblz;
            end
            if (ld) begin
                s0 = d0; s1 = d1; sblz = blz;
            end
            k++;
        end
    endtask

    // idle cycles carry junk data that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 4'($urandom), 4'($urandom),
                 1'($urandom));
        end
    endtask

    task automatic run_until(input int want);
        for (int i = 0; i < P && phase(k) != want; i++) begin
            idle(1);
        end
    endtask

    always begin
        obs_t got;
        obs_t exp;
        @(negedge clk);
        #2;
        if (expq.size() > 0) begin
            exp = expq.pop_front();
            got = {bus.an, bus.seg, bus.err};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL scan t=%0t got an=%b seg=%h err=%b want an=%b seg=%h err=%b",
                         $time, got.an, got.seg, got.err,
                         exp.an, exp.seg, exp.err);
            end
        end
    end

    initial begin
        bus.load     = 1'b0;
        bus.bcd0     = '0;
        bus.bcd1     = '0;
        bus.blank_lz = 1'b0;
        k = 0;
        s0 = '0; s1 = '0; sblz = 1'b0;
        a0 = '0; a1 = '0; ablz = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(14);

        run_until(1);
        step(1'b1, 1'b1, 4'd7, 4'd2, 1'b0);
        idle(24);

        step(1'b1, 1'b1, 4'd5, 4'd0, 1'b1);
        idle(24);
        step(1'b1, 1'b1, 4'd5, 4'd0, 1'b0);
        idle(24);

        step(1'b1, 1'b1, 4'd12, 4'd0, 1'b0);
        idle(24);
        step(1'b1, 1'b1, 4'd3, 4'd0, 1'b0);
        idle(24);

        run_until(P - 1);
        step(1'b1, 1'b1, 4'd9, 4'd8, 1'b0);
        idle(24);

        run_until(R + B + 1);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(20);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) != 0),
                 ($urandom_range(7) == 0),
                 4'($urandom), 4'($urandom),
                 1'($urandom));
        end

        for (int i = 0; i < 5 && expq.size() > 0; i++) begin
            @(negedge clk);
        end
        #3;
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL drain: pending=%0d want 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_mux.md
# bcd_display_mux

Two-digit, time-multiplexed seven-segment display driver sitting directly downstream of the 5-bit binary-to-BCD decoder. It captures a units/tens BCD pair on a load strobe and scans it onto a common-anode two-digit display. Scanning uses a programmable refresh rate and a blanking gap between digits to suppress ghosting. It also provides optional leading-zero suppression and an invalid-digit indication.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit is lit per scan slot (≥2).
- BLANK_CYCLES, 2: dead-time cycles with all digits off between slots (≥1).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- load  input  1  capture bcd0/bcd1/blank_lz into the shadow register this cycle.
- bcd0  input  4  units BCD digit (decoder out0).
- bcd1  input  4  tens BCD digit (decoder out1).
- blank_lz  input  1  when captured as 1, a tens digit of 0 is not lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  2  digit enables, an[0] units, an[1] tens, active-low.
- err  output  1  high while the displayed pair contains a digit >9.

## Operation
- Registers: shadow {bcd1,bcd0,blank_lz}, active copy of the same, 2-bit state, slot counter.
- FSM states: S_D0 (units lit), S_GAP0, S_D1 (tens lit), S_GAP1. Fixed cycle order D0→GAP0→D1→GAP1→D0.
- Counter: cleared on every state change. A state is left on the cycle where the counter equals its limit-1. The limit is REFRESH_DIV in S_D0/S_D1 and BLANK_CYCLES in the gaps.
- Transfer: shadow→active on the GAP1→D0 transition only. The displayed digits never change mid-scan.
- Load in the same cycle as a transfer: the transfer copies the old shadow, the shadow takes the new value, and the new value is shown at the following scan.
- Outputs are Moore, decoded from state and active registers only.
  - Gaps: an=11, seg=7F.
  - S_D0: an=10, seg=decode(active bcd0).
  - S_D1: an=01, seg=decode(active bcd1), except an=11 and seg=7F when active blank_lz=1 and bcd1=0.
- Decode (hex, active-low gfedcba): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10. Any value 10–15 shows dash 3F.
- err = (active bcd0>9) | (active bcd1>9). It clears automatically once a valid pair is transferred.

## Timing
- Reset (rst_n low at a clock edge):
  - state S_GAP1, counter 0, shadow and active all zero, blank_lz 0.
  - Outputs: seg=7F, an=11, err=0.
- After release, with cycle 0 as the first edge with rst_n high: S_GAP1 holds cycles 0..BLANK_CYCLES-1, and S_D0 starts at cycle BLANK_CYCLES, showing "00".
- Scan period: 2·(REFRESH_DIV+BLANK_CYCLES) cycles. Each digit is lit exactly REFRESH_DIV consecutive cycles per period.
- Load-to-display latency: from the load edge to the next GAP1→D0 transition, at most one scan period plus one cycle.
- Reset asserted mid-scan returns to the reset state at that edge, discarding any pending shadow value.
- Counter width: $clog2(max(REFRESH_DIV,BLANK_CYCLES)). No wrap past the limit.

## Structure
- Package bcd_display_pkg holds:
  - the state enum (S_D0, S_GAP0, S_D1, S_GAP1);
  - constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
- Sub-module seg7_decode (4-bit BCD in, 7-bit active-low segments out, dash for >9) is instantiated once, muxed between active digits.

## Test plan
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=2 (period 12).
- Reset then idle: an=11, seg=7F in cycles 0–1; an=10, seg=40 in cycles 2–5; an=11 in 6–7; an=01, seg=40 in 8–11; err=0.
- Load bcd1=2, bcd0=7 during S_D0 → the current scan still shows "00", and the next S_D0 shows seg=78 on an=10 and then seg=24 on an=01.
- Load bcd1=0, bcd0=5 with blank_lz=1 → units show 12 and the tens slot keeps an=11, seg=7F. Repeating with blank_lz=0 lights the tens digit with 40.
- Load bcd0=12 → after the transfer, the units slot shows 3F and err=1. A following load of 3 clears err and shows 30 at the next transfer.
- Load asserted on the last GAP1 cycle → the old value is displayed for one more scan, then the new one.
- Assert rst_n=0 mid-S_D1 → next cycle an=11, seg=7F, err=0, and the scan restarts per the reset sequence.
